axi_id_remap_lite: RTL
======================

AXI_ID_REMAP_LITE -- requirements
Module: axi_id_remap_lite

Interface
REQ-001 SHALL have parameter SlvIdWidth, default 4: ID width of the slave port, which is the wide ID produced by a crossbar master port.
REQ-002 SHALL have parameter MstIdWidth, default 2: ID width of the master port; 1 <= MstIdWidth <= SlvIdWidth.
REQ-003 SHALL have parameter MaxUniqIds, default 4: table entries per direction; 1 <= MaxUniqIds <= 2**MstIdWidth.
REQ-004 SHALL have parameter MaxTxnsPerId, default 4: maximum outstanding transactions per entry; >= 1.
REQ-005 SHALL have parameters slv_req_t, slv_rsp_t, mst_req_t, mst_rsp_t, default logic: port struct types with the standard AXI4 channel layout.
REQ-006 SHALL have port clk_i, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-007 SHALL have port rst_i, input, 1 bit: synchronous, active-high reset.
REQ-008 SHALL have port slv_req_i, input, slv_req_t: requests from upstream (crossbar master port).
REQ-009 SHALL have port slv_resp_o, output, slv_rsp_t: responses to upstream.
REQ-010 SHALL have port mst_req_o, output, mst_req_t: requests to the downstream slave with the narrow ID.
REQ-011 SHALL have port mst_resp_i, input, mst_rsp_t: responses from the downstream slave.

Function
REQ-012 SHALL keep two independent tables, write (AW/B) and read (AR/R); each entry holds a valid bit, the original slave ID, and a counter of $clog2(MaxTxnsPerId+1) bits.
REQ-013 SHALL look up each table combinationally on AW/AR: a hit is a valid entry whose stored ID equals the request ID.
REQ-014 SHALL, on a hit with counter < MaxTxnsPerId, forward the request with mst id = entry index, zero-extended to MstIdWidth.
REQ-015 SHALL, on a miss, allocate the lowest-index invalid entry, store the ID, set the counter to 1 on handshake, and forward with mst id = that index.
REQ-016 SHALL stall by holding slv ready=0 and mst valid=0 on a miss with no free entry, or on a hit with counter == MaxTxnsPerId.
REQ-017 SHALL otherwise pass AW/AR valid and ready combinationally, with zero added latency; all other Ax fields pass unchanged.
REQ-018 SHALL keep mst valid independent of mst ready; an asserted mst valid stays stable until handshake, because upstream holds valid.
REQ-019 SHALL pass the W channel through unchanged and combinationally.
REQ-020 SHALL return B with slv id = the stored ID of entry b.id; on B handshake the entry counter decrements and reaching 0 clears valid.
REQ-021 SHALL return R with slv id = the stored ID of entry r.id, for every beat; the decrement occurs only on a handshake with r.last=1.
REQ-022 SHALL, when increment and decrement of the same entry coincide in one cycle, leave the counter unchanged.
REQ-023 SHALL base allocation and stall decisions on the registered state only, so an entry freed in cycle N is allocatable from cycle N+1.
REQ-024 SHALL pass B/R ready and valid combinationally; other B/R fields pass unchanged.
REQ-025 SHALL support only atop == 0; a non-zero atop is out of scope and an SVA error.
REQ-026 SHALL flag as SVA errors a B or R whose id indexes an invalid entry, and any counter underflow.

Reset
REQ-027 SHALL, while rst_i=1 at a clock edge, clear all valid bits and counters in both tables.
REQ-028 SHALL force slv aw_ready, ar_ready, and w_ready to 0, and mst aw_valid, ar_valid, and w_valid to 0, while rst_i=1.
REQ-029 SHALL discard transactions in flight when reset is asserted mid-operation, with no responses replayed; the environment resets downstream together.
REQ-030 SHALL accept the first Ax in the cycle after rst_i deasserts.

Verification
REQ-031 SHALL cover: AW id=0xA after reset -> mst aw.id=0; B id=0 -> slv b.id=0xA; entry 0 freed.
REQ-032 SHALL cover: MaxTxnsPerId=4, five AR id=0x3 with no R -> four forwarded with id=0; fifth stalls until an R with last=1 returns.
REQ-033 SHALL cover: MaxUniqIds=4, AW ids 1,2,3,4 outstanding, then id 5 -> stalls; the B for id 2 (entry 1) frees the slot, and id 5 is issued next cycle with mst id=1.
REQ-034 SHALL cover: B handshake and new AW on the same id in the same cycle at counter=2 -> counter stays 2; mst id unchanged.
REQ-035 SHALL cover: 4-beat R burst id=0x7 -> all beats return slv id=0x7; the counter decrements only on the last beat.
REQ-036 SHALL cover: rst_i pulsed with 3 entries valid -> all ready and valid outputs 0 during reset; the next AW id=0xF maps to mst id=0.

Source files
------------

// File: rtl/axi_id_remap_lite.sv
// AXI4 ID remapper: compresses wide upstream IDs onto a small table of narrow
// downstream IDs, with independent write (AW/B) and read (AR/R) tables.

package axi_id_remap_lite_pkg;
    localparam int unsigned AddrWidth = 32;
    localparam int unsigned DataWidth = 32;
    localparam int unsigned UserWidth = 1;

    typedef struct packed {
        logic [3:0]           id;
        logic [AddrWidth-1:0] addr;
        logic [7:0]           len;
        logic [2:0]           size;
        logic [1:0]           burst;
        logic                 lock;
        logic [3:0]           cache;
        logic [2:0]           prot;
        logic [3:0]           qos;
        logic [3:0]           region;
        logic [5:0]           atop;
        logic [UserWidth-1:0] user;
    } slv_aw_chan_t;

    typedef struct packed {
        logic [1:0]           id;
        logic [AddrWidth-1:0] addr;
        logic [7:0]           len;
        logic [2:0]           size;
        logic [1:0]           burst;
        logic                 lock;
        logic [3:0]           cache;
        logic [2:0]           prot;
        logic [3:0]           qos;
        logic [3:0]           region;
        logic [5:0]           atop;
        logic [UserWidth-1:0] user;
    } mst_aw_chan_t;

    typedef struct packed {
        logic [3:0]           id;
        logic [AddrWidth-1:0] addr;
        logic [7:0]           len;
        logic [2:0]           size;
        logic [1:0]           burst;
        logic                 lock;
        logic [3:0]           cache;
        logic [2:0]           prot;
        logic [3:0]           qos;
        logic [3:0]           region;
        logic [UserWidth-1:0] user;
    } slv_ar_chan_t;

    typedef struct packed {
        logic [1:0]           id;
        logic [AddrWidth-1:0] addr;
        logic [7:0]           len;
        logic [2:0]           size;
        logic [1:0]           burst;
        logic                 lock;
        logic [3:0]           cache;
        logic [2:0]           prot;
        logic [3:0]           qos;
        logic [3:0]           region;
        logic [UserWidth-1:0] user;
    } mst_ar_chan_t;

    typedef struct packed {
        logic [DataWidth-1:0]   data;
        logic [DataWidth/8-1:0] strb;
        logic                   last;
        logic [UserWidth-1:0]   user;
    } w_chan_t;

    typedef struct packed {
        logic [3:0]           id;
        logic [1:0]           resp;
        logic [UserWidth-1:0] user;
    } slv_b_chan_t;

    typedef struct packed {
        logic [1:0]           id;
        logic [1:0]           resp;
        logic [UserWidth-1:0] user;
    } mst_b_chan_t;

    typedef struct packed {
        logic [3:0]           id;
        logic [DataWidth-1:0] data;
        logic [1:0]           resp;
        logic                 last;
        logic [UserWidth-1:0] user;
    } slv_r_chan_t;

    typedef struct packed {
        logic [1:0]           id;
        logic [DataWidth-1:0] data;
        logic [1:0]           resp;
        logic                 last;
        logic [UserWidth-1:0] user;
    } mst_r_chan_t;

    typedef struct packed {
        slv_aw_chan_t aw;
        logic         aw_valid;
        w_chan_t      w;
        logic         w_valid;
        logic         b_ready;
        slv_ar_chan_t ar;
        logic         ar_valid;
        logic         r_ready;
    } slv_req_t;

    typedef struct packed {
        logic        aw_ready;
        logic        ar_ready;
        logic        w_ready;
        logic        b_valid;
        slv_b_chan_t b;
        logic        r_valid;
        slv_r_chan_t r;
    } slv_rsp_t;

    typedef struct packed {
        mst_aw_chan_t aw;
        logic         aw_valid;
        w_chan_t      w;
        logic         w_valid;
        logic         b_ready;
        mst_ar_chan_t ar;
        logic         ar_valid;
        logic         r_ready;
    } mst_req_t;

    typedef struct packed {
        logic        aw_ready;
        logic        ar_ready;
        logic        w_ready;
        logic        b_valid;
        mst_b_chan_t b;
        logic        r_valid;
        mst_r_chan_t r;
    } mst_rsp_t;
endpackage

// One direction's remap table: request-side lookup/allocation and
// response-side reverse lookup with per-entry outstanding counters.
module axi_id_remap_lite_table #(
    parameter int unsigned SlvIdWidth   = 4,
    parameter int unsigned MstIdWidth   = 2,
    parameter int unsigned MaxUniqIds   = 4,
    parameter int unsigned MaxTxnsPerId = 4
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  req_valid,
    input  logic [SlvIdWidth-1:0] req_id,
    input  logic                  dn_ready,
    output logic                  req_ok,
    output logic [MstIdWidth-1:0] req_mst_id,
    input  logic                  rsp_valid,
    input  logic [MstIdWidth-1:0] rsp_id,
    input  logic                  rsp_done,
    output logic [SlvIdWidth-1:0] rsp_slv_id
);
    localparam int unsigned IdxW = (MaxUniqIds > 1) ? $clog2(MaxUniqIds) : 1;
    localparam int unsigned CntW = $clog2(MaxTxnsPerId + 1);
    localparam logic [CntW-1:0] MaxCnt = CntW'(MaxTxnsPerId);

    logic [MaxUniqIds-1:0] valid_q;
    logic [SlvIdWidth-1:0] id_q  [MaxUniqIds];
    logic [CntW-1:0]       cnt_q [MaxUniqIds];
    logic                  held_q;
    logic [IdxW-1:0]       held_idx_q;

    logic                  hit, any_free, usable, inc, dec, rsp_in_range;
    logic [IdxW-1:0]       hit_idx, free_idx, sel_idx, rsp_idx;
    logic [MaxUniqIds-1:0] inc_vec, dec_vec;

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        hit      = 1'b0;
        hit_idx  = '0;
        any_free = 1'b0;
        free_idx = '0;
        // Descending scan so the lowest matching/free index wins.
        for (int i = int'(MaxUniqIds) - 1; i >= 0; i--) begin
            if (valid_q[i] && id_q[i] == req_id) begin
                hit     = 1'b1;
                hit_idx = IdxW'(i);
            end
            if (!valid_q[i]) begin
                any_free = 1'b1;
                free_idx = IdxW'(i);
            end
        end

        // A request stalled only by downstream ready keeps its index so the
        // presented mst id cannot change before the handshake.
        if (held_q) begin
            sel_idx = held_idx_q;
            usable  = !valid_q[held_idx_q] || (cnt_q[held_idx_q] < MaxCnt);
        end else if (hit) begin
            sel_idx = hit_idx;
            usable  = cnt_q[hit_idx] < MaxCnt;
        end else begin
            sel_idx = free_idx;
            usable  = any_free;
        end

        req_ok     = usable && !rst_i;
        req_mst_id = MstIdWidth'(sel_idx);
        inc        = req_valid && req_ok && dn_ready;

        rsp_in_range = 32'(rsp_id) < MaxUniqIds;
        rsp_idx      = rsp_in_range ? IdxW'(rsp_id) : '0;
        rsp_slv_id   = id_q[rsp_idx];
        dec          = rsp_done && rsp_in_range;

        for (int i = 0; i < int'(MaxUniqIds); i++) begin
            inc_vec[i] = inc && (sel_idx == IdxW'(i));
            dec_vec[i] = dec && (rsp_idx == IdxW'(i));
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            valid_q    <= '0;
            held_q     <= 1'b0;
            held_idx_q <= '0;
            for (int i = 0; i < int'(MaxUniqIds); i++) cnt_q[i] <= '0;
        end else begin
            held_q     <= req_valid && req_ok && !dn_ready;
            held_idx_q <= sel_idx;
            for (int i = 0; i < int'(MaxUniqIds); i++) begin
                if (inc_vec[i] && !dec_vec[i]) begin
                    cnt_q[i]   <= cnt_q[i] + CntW'(1);
                    valid_q[i] <= 1'b1;
                end else if (dec_vec[i] && !inc_vec[i]) begin
                    cnt_q[i] <= cnt_q[i] - CntW'(1);
                    if (cnt_q[i] == CntW'(1)) valid_q[i] <= 1'b0;
                end
            end
        end
    end

    // NOTE: the stored IDs are storage qualified by valid_q, so they carry no reset.
    always_ff @(posedge clk_i) begin
        for (int i = 0; i < int'(MaxUniqIds); i++) begin
            if (inc_vec[i] && !valid_q[i]) id_q[i] <= req_id;
        end
    end

    a_rsp_valid_entry: assert property (@(posedge clk_i) disable iff (rst_i)
        rsp_valid |-> (rsp_in_range && valid_q[rsp_idx]))
        else $error("response id does not map to a valid entry");

    a_no_underflow: assert property (@(posedge clk_i) disable iff (rst_i)
        (rsp_done && rsp_in_range) |-> (cnt_q[rsp_idx] != '0))
        else $error("outstanding counter underflow");
endmodule

module axi_id_remap_lite #(
    parameter int unsigned SlvIdWidth   = 4,
    parameter int unsigned MstIdWidth   = 2,
    parameter int unsigned MaxUniqIds   = 4,
    parameter int unsigned MaxTxnsPerId = 4,
    parameter type slv_req_t = axi_id_remap_lite_pkg::slv_req_t,
    parameter type slv_rsp_t = axi_id_remap_lite_pkg::slv_rsp_t,
    parameter type mst_req_t = axi_id_remap_lite_pkg::mst_req_t,
    parameter type mst_rsp_t = axi_id_remap_lite_pkg::mst_rsp_t
) (
    input  logic     clk_i,
    input  logic     rst_i,
    input  slv_req_t slv_req_i,
    output slv_rsp_t slv_resp_o,
    output mst_req_t mst_req_o,
    input  mst_rsp_t mst_resp_i
);
    logic                  aw_ok, ar_ok;
    logic [MstIdWidth-1:0] aw_mst_id, ar_mst_id;
    logic [SlvIdWidth-1:0] b_slv_id, r_slv_id;

    axi_id_remap_lite_table #(
        .SlvIdWidth  (SlvIdWidth),
        .MstIdWidth  (MstIdWidth),
        .MaxUniqIds  (MaxUniqIds),
        .MaxTxnsPerId(MaxTxnsPerId)
    ) u_wr_table (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .req_valid (slv_req_i.aw_valid),
        .req_id    (slv_req_i.aw.id),
        .dn_ready  (mst_resp_i.aw_ready),
        .req_ok    (aw_ok),
        .req_mst_id(aw_mst_id),
        .rsp_valid (mst_resp_i.b_valid),
        .rsp_id    (mst_resp_i.b.id),
        .rsp_done  (mst_resp_i.b_valid && slv_req_i.b_ready),
        .rsp_slv_id(b_slv_id)
    );

    axi_id_remap_lite_table #(
        .SlvIdWidth  (SlvIdWidth),
        .MstIdWidth  (MstIdWidth),
        .MaxUniqIds  (MaxUniqIds),
        .MaxTxnsPerId(MaxTxnsPerId)
    ) u_rd_table (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .req_valid (slv_req_i.ar_valid),
        .req_id    (slv_req_i.ar.id),
        .dn_ready  (mst_resp_i.ar_ready),
        .req_ok    (ar_ok),
        .req_mst_id(ar_mst_id),
        .rsp_valid (mst_resp_i.r_valid),
        .rsp_id    (mst_resp_i.r.id),
        .rsp_done  (mst_resp_i.r_valid && slv_req_i.r_ready && mst_resp_i.r.last),
        .rsp_slv_id(r_slv_id)
    );

    always_comb begin
        mst_req_o  = '0;
        slv_resp_o = '0;

        mst_req_o.aw.id     = aw_mst_id;
        mst_req_o.aw.addr   = slv_req_i.aw.addr;
        mst_req_o.aw.len    = slv_req_i.aw.len;
        mst_req_o.aw.size   = slv_req_i.aw.size;
        mst_req_o.aw.burst  = slv_req_i.aw.burst;
        mst_req_o.aw.lock   = slv_req_i.aw.lock;
        mst_req_o.aw.cache  = slv_req_i.aw.cache;
        mst_req_o.aw.prot   = slv_req_i.aw.prot;
        mst_req_o.aw.qos    = slv_req_i.aw.qos;
        mst_req_o.aw.region = slv_req_i.aw.region;
        mst_req_o.aw.atop   = slv_req_i.aw.atop;
        mst_req_o.aw.user   = slv_req_i.aw.user;
        mst_req_o.aw_valid  = slv_req_i.aw_valid && aw_ok;
        slv_resp_o.aw_ready = mst_resp_i.aw_ready && aw_ok;

        mst_req_o.ar.id     = ar_mst_id;
        mst_req_o.ar.addr   = slv_req_i.ar.addr;
        mst_req_o.ar.len    = slv_req_i.ar.len;
        mst_req_o.ar.size   = slv_req_i.ar.size;
        mst_req_o.ar.burst  = slv_req_i.ar.burst;
        mst_req_o.ar.lock   = slv_req_i.ar.lock;
        mst_req_o.ar.cache  = slv_req_i.ar.cache;
        mst_req_o.ar.prot   = slv_req_i.ar.prot;
        mst_req_o.ar.qos    = slv_req_i.ar.qos;
        mst_req_o.ar.region = slv_req_i.ar.region;
        mst_req_o.ar.user   = slv_req_i.ar.user;
        mst_req_o.ar_valid  = slv_req_i.ar_valid && ar_ok;
        slv_resp_o.ar_ready = mst_resp_i.ar_ready && ar_ok;

        mst_req_o.w        = slv_req_i.w;
        mst_req_o.w_valid  = slv_req_i.w_valid && !rst_i;
        slv_resp_o.w_ready = mst_resp_i.w_ready && !rst_i;

        slv_resp_o.b.id    = b_slv_id;
        slv_resp_o.b.resp  = mst_resp_i.b.resp;
        slv_resp_o.b.user  = mst_resp_i.b.user;
        slv_resp_o.b_valid = mst_resp_i.b_valid;
        mst_req_o.b_ready  = slv_req_i.b_ready;

        slv_resp_o.r.id    = r_slv_id;
        slv_resp_o.r.data  = mst_resp_i.r.data;
        slv_resp_o.r.resp  = mst_resp_i.r.resp;
        slv_resp_o.r.last  = mst_resp_i.r.last;
        slv_resp_o.r.user  = mst_resp_i.r.user;
        slv_resp_o.r_valid = mst_resp_i.r_valid;
        mst_req_o.r_ready  = slv_req_i.r_ready;
    end

    // Atomic transactions would need response tracking this block does not have.
    a_no_atop: assert property (@(posedge clk_i) disable iff (rst_i)
        slv_req_i.aw_valid |-> (slv_req_i.aw.atop == '0))
        else $error("atomic AW (atop != 0) is not supported");
endmodule
